sccb_config_sequencer: RTL
==========================

SCCB_CONFIG_SEQUENCER -- requirements
Module: sccb_config_sequencer

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h21, the 7-bit camera bus address used for every write.
REQ-002 SHALL have parameter ROM_AW, default 8, the config-table address width (2^ROM_AW entries).
REQ-003 SHALL have parameter DELAY_UNIT_CYCLES, default 27000, the clocks per delay unit (1 ms at 27 MHz).
REQ-004 SHALL have parameter MAX_RETRY, default 3, the maximum number of re-issues of a NACKed write.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; clock and reset are listed first.
REQ-006 Port clk, input, 1, system clock.
REQ-007 Port reset_n, input, 1, asynchronous active-low reset.
REQ-008 Port start, input, 1, one-cycle request to run the table.
REQ-009 Port rom_addr, output, ROM_AW, table read address.
REQ-010 Port rom_data, input, 16, table word {reg[15:8], val[7:0]}, valid one cycle after rom_addr.
REQ-011 Port xfer_req, output, 1, write-transaction request to the bus master.
REQ-012 Port xfer_ack, input, 1, master accepted the request.
REQ-013 Port xfer_dev / xfer_reg / xfer_data, output, 7/8/8, device address, register, value.
REQ-014 Port xfer_done, input, 1, one-cycle pulse when the transaction ends.
REQ-015 Port xfer_nack, input, 1, qualified by xfer_done; 1 means the slave did not acknowledge.
REQ-016 Port busy / done / error, output, 1 each, status flags.
REQ-017 Port err_index, output, ROM_AW, table index of the failing entry.

Function
REQ-018 States SHALL be IDLE, FETCH, DECODE, ISSUE, WAIT, DELAY, NEXT, DONE, ERROR.
REQ-019 In IDLE, DONE or ERROR, start=1 SHALL clear done, error and rom_addr, set busy, and go to FETCH; start SHALL be ignored in all other states.
REQ-020 FETCH SHALL last exactly one cycle (ROM latency) and then go to DECODE.
REQ-021 In DECODE, rom_data==16'hFFFF SHALL be the end marker and go to DONE.
REQ-022 In DECODE, rom_data[15:8]==8'hFE SHALL be a delay of rom_data[7:0] units and go to DELAY; a count of 0 SHALL go straight to NEXT.
REQ-023 In DECODE, any other word SHALL latch xfer_reg=rom_data[15:8] and xfer_data=rom_data[7:0], clear the retry count, and go to ISSUE.
REQ-024 xfer_dev SHALL equal SLAVE_ADDR at all times.
REQ-025 In ISSUE, xfer_req SHALL be held at 1 with stable xfer_reg/xfer_data until the first cycle with xfer_ack=1; xfer_req SHALL drop the next cycle and the state SHALL go to WAIT.
REQ-026 In WAIT, xfer_done=1 with xfer_nack=0 SHALL go to NEXT.
REQ-027 In WAIT, xfer_done=1 with xfer_nack=1 and retry count < MAX_RETRY SHALL increment the count and return to ISSUE.
REQ-028 Otherwise the NACK SHALL go to ERROR with err_index=rom_addr, error=1, busy=0.
REQ-029 DELAY SHALL remain for exactly count*DELAY_UNIT_CYCLES clocks and then go to NEXT; the counter SHALL be wide enough for 255*DELAY_UNIT_CYCLES.
REQ-030 NEXT SHALL increment rom_addr and go to FETCH.
REQ-031 If rom_addr is at 2^ROM_AW-1 in NEXT, NEXT SHALL go to DONE (no wrap) instead.
REQ-032 DONE SHALL set done=1 and busy=0; both SHALL hold until the next accepted start.
REQ-033 An xfer_done pulse outside WAIT SHALL be ignored.

Reset
REQ-034 reset_n=0 SHALL asynchronously force IDLE, rom_addr=0, xfer_req=0, xfer_reg=0, xfer_data=0, busy=0, done=0, error=0, err_index=0, and clear the retry and delay counters.
REQ-035 Reset asserted during any state, including mid-transaction or mid-delay, SHALL abandon the operation; no request SHALL be reissued until a new start.

Verification
REQ-036 Table {0x1280, 0x1101, 0xFFFF}, slave always ACKs -> exactly two requests, (0x12,0x80) then (0x11,0x01); done=1; rom_addr ends at 2.
REQ-037 Table {0xFE02, 0xFFFF}, DELAY_UNIT_CYCLES=10 -> no xfer_req; exactly 20 cycles spent in DELAY; done=1.
REQ-038 Entry 0x3A04 NACKed twice then ACKed, MAX_RETRY=3 -> three requests; done=1; error=0.
REQ-039 Entry at index 1 always NACKed -> exactly 4 requests; error=1; err_index=1; busy=0; done=0.
REQ-040 Hold xfer_ack low for 5 cycles -> xfer_req stays high with stable data; start pulses while busy are ignored.
REQ-041 Assert reset_n=0 mid-DELAY, then release and pulse start -> the sequence restarts from index 0.

Source files
------------

// File: rtl/sccb_config_sequencer.sv
// ---------------------------------------------------------------------------
// sccb_config_sequencer
//
// Walks a camera register-configuration table and turns each entry into a
// write transaction for an external SCCB/I2C bus master.
//
// Table word format is {reg[15:8], val[7:0]}:
//   16'hFFFF         end of table
//   {8'hFE, n}       pause for n * DELAY_UNIT_CYCLES clocks
//   anything else    write val to register reg of device SLAVE_ADDR
//
// A NACKed write is re-issued up to MAX_RETRY times. After that the run
// stops with error set and err_index pointing at the failing entry.
//
// Ports
//   clk, reset_n         system clock, asynchronous active-low reset
//   start                one-cycle request to run the table (IDLE/DONE/ERROR only)
//   rom_addr, rom_data   table read port; data is valid one cycle after the address
//   xfer_req, xfer_ack   write request to the bus master and its acceptance
//   xfer_dev/reg/data    device address, register and value of the write
//   xfer_done, xfer_nack end-of-transaction pulse; nack qualifies the pulse
//   busy, done, error    status flags
//   err_index            table index of the entry that exhausted its retries
// ---------------------------------------------------------------------------
module sccb_config_sequencer #(
  parameter logic [6:0] SLAVE_ADDR        = 7'h21,
  parameter int         ROM_AW            = 8,
  parameter int         DELAY_UNIT_CYCLES = 27000,
  parameter int         MAX_RETRY         = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              xfer_req,
  input  logic              xfer_ack,
  output logic [6:0]        xfer_dev,
  output logic [7:0]        xfer_reg,
  output logic [7:0]        xfer_data,
  input  logic              xfer_done,
  input  logic              xfer_nack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ROM_AW-1:0] err_index
);

  // The delay counter must hold the longest pause (255 units).
  localparam int DLY_RAW = $clog2(255 * DELAY_UNIT_CYCLES + 1);
  localparam int DLY_W   = (DLY_RAW > 0) ? DLY_RAW : 1;
  localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [ROM_AW-1:0] LAST_ADDR = '1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT,
    ST_DELAY,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } state_e;

  state_e            state_q,     state_d;
  logic [ROM_AW-1:0] romAddr_q,   romAddr_d;
  logic              xferReq_q,   xferReq_d;
  logic [7:0]        xferReg_q,   xferReg_d;
  logic [7:0]        xferData_q,  xferData_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              error_q,     error_d;
  logic [ROM_AW-1:0] errIndex_q,  errIndex_d;
  logic [RTY_W-1:0]  retryCnt_q,  retryCnt_d;
  logic [DLY_W-1:0]  dlyCnt_q,    dlyCnt_d;
  logic [DLY_W-1:0]  dlyLoad;

  // Total clocks requested by a delay entry; zero means skip DELAY entirely.
  assign dlyLoad = DLY_W'(rom_data[7:0]) * DLY_W'(DELAY_UNIT_CYCLES);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      romAddr_q  <= '0;
      xferReq_q  <= 1'b0;
      xferReg_q  <= '0;
      xferData_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      errIndex_q <= '0;
      retryCnt_q <= '0;
      dlyCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      romAddr_q  <= romAddr_d;
      xferReq_q  <= xferReq_d;
      xferReg_q  <= xferReg_d;
      xferData_q <= xferData_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      errIndex_q <= errIndex_d;
      retryCnt_q <= retryCnt_d;
      dlyCnt_q   <= dlyCnt_d;
    end
  end

  // xfer_req is registered and raised on every entry into ISSUE, so it is
  // high for exactly the cycles the FSM spends in ISSUE.
  always_comb begin
    state_d    = state_q;
    romAddr_d  = romAddr_q;
    xferReq_d  = xferReq_q;
    xferReg_d  = xferReg_q;
    xferData_d = xferData_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    errIndex_d = errIndex_q;
    retryCnt_d = retryCnt_q;
    dlyCnt_d   = dlyCnt_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          romAddr_d = '0;
          done_d    = 1'b0;
          error_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_FETCH;
        end
      end

      ST_FETCH: state_d = ST_DECODE;

      ST_DECODE: begin
        if (rom_data == 16'hFFFF) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else if (rom_data[15:8] == 8'hFE) begin
          dlyCnt_d = dlyLoad;
          state_d  = (dlyLoad == '0) ? ST_NEXT : ST_DELAY;
        end else begin
          xferReg_d  = rom_data[15:8];
          xferData_d = rom_data[7:0];
          retryCnt_d = '0;
          xferReq_d  = 1'b1;
          state_d    = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (xfer_ack) begin
          xferReq_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (xfer_done) begin
          if (!xfer_nack) begin
            state_d = ST_NEXT;
          end else if (retryCnt_q < RTY_W'(MAX_RETRY)) begin
            retryCnt_d = retryCnt_q + RTY_W'(1);
            xferReq_d  = 1'b1;
            state_d    = ST_ISSUE;
          end else begin
            errIndex_d = romAddr_q;
            error_d    = 1'b1;
            busy_d     = 1'b0;
            state_d    = ST_ERROR;
          end
        end
      end

      // Counter was loaded with the full length, so leaving on 1 gives
      // exactly that many cycles in DELAY.
      ST_DELAY: begin
        if (dlyCnt_q <= DLY_W'(1)) begin
          dlyCnt_d = '0;
          state_d  = ST_NEXT;
        end else begin
          dlyCnt_d = dlyCnt_q - DLY_W'(1);
        end
      end

      // The table does not wrap: running off the last entry ends the run.
      ST_NEXT: begin
        if (romAddr_q == LAST_ADDR) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          romAddr_d = romAddr_q + ROM_AW'(1);
          state_d   = ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign rom_addr  = romAddr_q;
  assign xfer_req  = xferReq_q;
  assign xfer_dev  = SLAVE_ADDR;
  assign xfer_reg  = xferReg_q;
  assign xfer_data = xferData_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_index = errIndex_q;

endmodule
